// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame field sizes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BASE_BYTES        = 4;
  localparam int         COUNT_BYTES       = 4;
  localparam int         WORD_BYTES        = 4;

  // Number of bytes the packer collects in a given field state.
  function automatic int field_len(input state_t s);
    case (s)
      S_ADDR:  return BASE_BYTES;
      S_LEN:   return COUNT_BYTES;
      S_DATA:  return WORD_BYTES;
      default: return 1;
    endcase
  endfunction

  // States that wait on the byte stream (subject to the inter-byte timeout).
  function automatic logic is_wait_state(input state_t s);
    return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Little-endian 4-byte shift/pack register with byte counter, reused for BASE, COUNT and data words.
module imem_loader_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [1:0]  i_last_idx,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [31:0] o_word_next,
  output logic        o_last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Place the incoming byte at lane cnt and advance/wrap the lane counter.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clr) begin
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else if (i_shift) begin
      case (cnt_q)
        2'd0:    word_d[7:0]   = i_byte;
        2'd1:    word_d[15:8]  = i_byte;
        2'd2:    word_d[23:16] = i_byte;
        2'd3:    word_d[31:24] = i_byte;
        default: word_d        = word_q;
      endcase
      if (cnt_q == i_last_idx) begin
        cnt_d = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pack register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word      = word_q;
  assign o_word_next = word_d;
  assign o_last      = i_shift && !i_clr && (cnt_q == i_last_idx);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader writing the instruction BRAM and gating CPU release on checksum.
// Optional inter-byte timeout enabled by defining IMEM_LOADER_TIMEOUT_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_WORDS      = 16384,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_en,
  output logic        o_we,
  output logic        o_cpu_halt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t            state_q, state_d, state_case_s;
  logic [31:0]       addr_q, addr_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc_s;
  logic [7:0]        csum_q, csum_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic              acc_s, sync_s, tmo_hit_s;
  logic              pk_clr_s, pk_shift_s, pk_last_s;
  logic [1:0]        pk_last_idx_s;
  logic [31:0]       pk_word_s, pk_word_next_s;

  assign acc_s         = i_byte_valid && ready_q;
  assign sync_s        = acc_s && (state_q == S_IDLE) && (i_byte == SYNC_BYTE);
  assign pk_last_idx_s = 2'(field_len(state_q) - 1);
  assign idx_inc_s     = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

  imem_loader_pack u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (pk_clr_s),
    .i_shift     (pk_shift_s),
    .i_last_idx  (pk_last_idx_s),
    .i_byte      (i_byte),
    .o_word      (pk_word_s),
    .o_word_next (pk_word_next_s),
    .o_last      (pk_last_s)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Idle-cycle counter: cleared by any accepted byte, runs only while a frame is open.
  always_comb begin
    if (acc_s || !busy_q) begin
      tmo_d = 32'd0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit_s = (tmo_q == 32'(TIMEOUT_CYCLES));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Frame FSM: next state, field capture and registered output values.
  always_comb begin
    state_case_s = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    pk_clr_s     = 1'b0;
    pk_shift_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sync_s) begin
          state_case_s = S_ADDR;
          csum_d       = 8'h00;
          idx_d        = {IDX_W{1'b0}};
          pk_clr_s     = 1'b1;
        end else begin
          state_case_s = S_IDLE;
        end
      end
      S_ADDR: begin
        pk_shift_s = acc_s;
        if (pk_last_s) begin
          addr_d       = pk_word_next_s;
          state_case_s = (pk_word_next_s[1:0] != 2'b00) ? S_ERR : S_LEN;
        end else begin
          state_case_s = S_ADDR;
        end
      end
      S_LEN: begin
        pk_shift_s = acc_s;
        if (pk_last_s) begin
          count_d = pk_word_next_s[IDX_W-1:0];
          if (pk_word_next_s > 32'(MAX_WORDS)) begin
            state_case_s = S_ERR;
          end else if (pk_word_next_s == 32'd0) begin
            state_case_s = S_CSUM;
          end else begin
            state_case_s = S_DATA;
          end
        end else begin
          state_case_s = S_LEN;
        end
      end
      S_DATA: begin
        pk_shift_s = acc_s;
        if (acc_s) begin
          csum_d = csum_q ^ i_byte;
        end else begin
          csum_d = csum_q;
        end
        state_case_s = pk_last_s ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        addr_d       = addr_q + 32'd4;
        idx_d        = idx_inc_s;
        state_case_s = (idx_inc_s == count_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (acc_s) begin
          state_case_s = (i_byte == csum_q) ? S_DONE : S_ERR;
        end else begin
          state_case_s = S_CSUM;
        end
      end
      S_DONE:  state_case_s = S_IDLE;
      S_ERR:   state_case_s = S_IDLE;
      default: state_case_s = S_IDLE;
    endcase

    state_d = (tmo_hit_s && !acc_s && is_wait_state(state_q)) ? S_ERR : state_case_s;

    ready_d = !((state_d == S_WRITE) || (state_d == S_DONE) || (state_d == S_ERR));
    busy_d  = (state_d == S_ADDR) || (state_d == S_LEN) || (state_d == S_DATA) ||
              (state_d == S_WRITE) || (state_d == S_CSUM);
    done_d  = (state_d == S_DONE);
    en_d    = (state_d == S_WRITE);

    // Halt is released only by a verified image; errors leave the CPU held.
    if (sync_s) begin
      halt_d = 1'b1;
    end else if (state_d == S_DONE) begin
      halt_d = 1'b0;
    end else begin
      halt_d = halt_q;
    end

    if (sync_s) begin
      err_d = 1'b0;
    end else if (state_d == S_ERR) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0000_0000;
      count_q <= {IDX_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      csum_q  <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_addr       = addr_q;
  assign o_wdata      = pk_word_s;
  assign o_en         = en_q;
  assign o_we         = en_q;
  assign o_cpu_halt   = halt_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected BRAM writes queued at stimulus time, checked by a monitor.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready, o_en, o_we, o_cpu_halt, o_busy, o_done, o_err;
  logic [31:0] o_addr, o_wdata;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_low_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .o_en         (o_en),
    .o_we         (o_we),
    .o_cpu_halt   (o_cpu_halt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every BRAM write and watches done/ready.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rst_n) begin
      if (o_en || o_we) begin
        chk("en_we_pair", {31'd0, o_we}, {31'd0, o_en});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h:%h required=none", o_addr, o_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", o_addr, e[63:32]);
          chk("wr_data", o_wdata, e[31:0]);
        end
      end
      if (o_done) begin
        done_cnt++;
        chk("halt_at_done", {31'd0, o_cpu_halt}, 32'd0);
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
      end
      if (!o_byte_ready) rdy_low_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_u32(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic send_hdr(input logic [31:0] base, input logic [31:0] count);
    send_byte(8'hA5);
    send_u32(base);
    send_u32(count);
  endtask

  task automatic idle(input int n);
    i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_end(input string tag, input int exp_done, input logic exp_err,
                           input logic exp_halt);
    idle(4);
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
    chk({tag, "_halt"}, {31'd0, o_cpu_halt}, {31'd0, exp_halt});
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    done_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd1);
    chk({tag, "_halt"}, {31'd0, o_cpu_halt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_en"}, {30'd0, o_en, o_we}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
    chk({tag, "_addr"}, o_addr, 32'd0);
    chk({tag, "_wdata"}, o_wdata, 32'd0);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Good two-word image; checksum 93^13^01^10 = 91.
    exp_q.push_back({32'h0000_0000, 32'h0000_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_0113});
    rdy_low_cnt = 0;
    send_hdr(32'h0, 32'd2);
    send_u32(32'h0000_0093);
    send_u32(32'h0010_0113);
    send_byte(8'h91);
    frame_end("good", 1, 1'b0, 1'b0);
    chk("good_rdy_low", 32'(rdy_low_cnt), 32'd3);

    // Same image, bad checksum: writes happen, CPU stays halted.
    exp_q.push_back({32'h0000_0000, 32'h0000_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_0113});
    send_hdr(32'h0, 32'd2);
    send_u32(32'h0000_0093);
    send_u32(32'h0010_0113);
    send_byte(8'h00);
    frame_end("badcs", 0, 1'b1, 1'b1);

    exp_q.push_back({32'h0000_0000, 32'h0000_0093});
    exp_q.push_back({32'h0000_0004, 32'h0010_0113});
    send_hdr(32'h0, 32'd2);
    send_u32(32'h0000_0093);
    send_u32(32'h0010_0113);
    send_byte(8'h91);
    frame_end("recover", 1, 1'b0, 1'b0);

    // Misaligned base: error right after the address field.
    send_byte(8'hA5);
    send_u32(32'h0000_0002);
    frame_end("misalign", 0, 1'b1, 1'b1);

    // Oversized count.
    send_byte(8'hA5);
    send_u32(32'h0000_0000);
    send_u32(32'd16385);
    frame_end("toobig", 0, 1'b1, 1'b1);

    // Junk before SYNC, then an empty image.
    send_byte(8'h11);
    chk("junk1_busy", {31'd0, o_busy}, 32'd0);
    send_byte(8'h22);
    chk("junk2_busy", {31'd0, o_busy}, 32'd0);
    send_hdr(32'h0000_0040, 32'd0);
    send_byte(8'h00);
    frame_end("empty", 1, 1'b0, 1'b0);

    // Back-to-back bytes over three words; checksum AA^BB^CC = DD.
    exp_q.push_back({32'h0000_0100, 32'h0000_00AA});
    exp_q.push_back({32'h0000_0104, 32'h0000_BB00});
    exp_q.push_back({32'h0000_0108, 32'h00CC_0000});
    rdy_low_cnt = 0;
    send_hdr(32'h0000_0100, 32'd3);
    send_u32(32'h0000_00AA);
    send_u32(32'h0000_BB00);
    send_u32(32'h00CC_0000);
    send_byte(8'hDD);
    frame_end("stream", 1, 1'b0, 1'b0);
    chk("stream_rdy_low", 32'(rdy_low_cnt), 32'd4);

    // Reset in the middle of the second word.
    exp_q.push_back({32'h0000_0200, 32'h1234_5678});
    send_hdr(32'h0000_0200, 32'd2);
    send_u32(32'h1234_5678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    done_cnt = 0;

    // Stall mid-word; checksum EF^BE^AD^DE = 22.
    send_hdr(32'h0000_0300, 32'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    idle(60);
`ifdef IMEM_LOADER_TIMEOUT_EN
    chk("stall_err", {31'd0, o_err}, 32'd1);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_byte(8'h22);
    frame_end("stall", 0, 1'b1, 1'b1);
`else
    chk("stall_busy", {31'd0, o_busy}, 32'd1);
    exp_q.push_back({32'h0000_0300, 32'hDEAD_BEEF});
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_byte(8'h22);
    frame_end("stall", 1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
